// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-line instruction cache between fetch and instruction memory.
// Hits respond one per cycle; misses issue a single outstanding backing read.
module icache_direct #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        inval_i,
  input  logic [29:0] req_addr_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  output logic [29:0] resp_addr_o,
  output logic [31:0] resp_data_o,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [29:0] mem_req_addr_o,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  input  logic [31:0] mem_resp_data_i,
  input  logic        mem_resp_valid_i
);
  localparam int TAG_BITS = 30 - INDEX_BITS;
  localparam int LINES = 2 ** INDEX_BITS;
  localparam logic [INDEX_BITS-1:0] CNT_LAST = INDEX_BITS'(LINES - 1);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // a valid source holds its payload stable until that edge.
  typedef enum logic [2:0] {
    S_CLEAR, S_READY, S_MISS_REQ, S_MISS_WAIT, S_DRAIN
  } state_t;

  state_t state_q, state_d;
  logic [INDEX_BITS-1:0] cnt_q;
  logic pending_q, discard_q;

  logic                valid_q [LINES];
  logic [TAG_BITS-1:0] tag_q   [LINES];
  logic [31:0]         data_q  [LINES];

  logic [INDEX_BITS-1:0] req_idx, fill_idx;
  logic [TAG_BITS-1:0]   req_tag, fill_tag;
  logic hit, accept, mem_hs, fill_we, fill_resp;

  assign req_idx  = req_addr_i[INDEX_BITS-1:0];
  assign req_tag  = req_addr_i[29:INDEX_BITS];
  // The issued read address doubles as the latched miss address for the fill.
  assign fill_idx = mem_req_addr_o[INDEX_BITS-1:0];
  assign fill_tag = mem_req_addr_o[29:INDEX_BITS];
  assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign accept   = req_valid_i && req_ready_o;
  assign mem_hs   = mem_req_valid_o && mem_req_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_CLEAR;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CLEAR: if (cnt_q == CNT_LAST)
        state_d = (pending_q && !mem_resp_valid_i) ? S_DRAIN : S_READY;
      S_READY: if (accept && !hit) state_d = S_MISS_REQ;
      S_MISS_REQ: begin
        if (flush_i)              state_d = mem_req_ready_i ? S_DRAIN : S_READY;
        else if (mem_req_ready_i) state_d = S_MISS_WAIT;
      end
      S_MISS_WAIT: begin
        if (mem_resp_valid_i) state_d = S_READY;
        else if (flush_i)     state_d = S_DRAIN;
      end
      S_DRAIN: if (mem_resp_valid_i) state_d = S_READY;
      default: state_d = S_CLEAR;
    endcase
    if (inval_i) state_d = S_CLEAR;
  end

  always_comb begin
    req_ready_o = 1'b0;
    fill_we     = 1'b0;
    fill_resp   = 1'b0;
    case (state_q)
      S_READY:     req_ready_o = (!resp_valid_o || resp_ready_i) && !inval_i && !rst_i;
      S_MISS_WAIT: begin
        fill_we   = mem_resp_valid_i && !inval_i;
        fill_resp = mem_resp_valid_i && !inval_i && !flush_i;
      end
      S_DRAIN:     fill_we = mem_resp_valid_i && !inval_i && !discard_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q           <= '0;
      pending_q       <= 1'b0;
      discard_q       <= 1'b0;
      resp_valid_o    <= 1'b0;
      resp_addr_o     <= '0;
      resp_data_o     <= '0;
      mem_req_valid_o <= 1'b0;
      mem_req_addr_o  <= '0;
    end else begin
      if (inval_i)                cnt_q <= '0;
      else if (state_q == S_CLEAR) cnt_q <= cnt_q + 1'b1;

      if (mem_resp_valid_i) pending_q <= 1'b0;
      else if (mem_hs)      pending_q <= 1'b1;

      // A drain entered from the sweep discards the fill: its line was just invalidated.
      if (state_d == S_DRAIN && state_q != S_DRAIN) discard_q <= (state_q == S_CLEAR);

      if (resp_ready_i || flush_i) resp_valid_o <= 1'b0;
      if (accept && hit) begin
        resp_valid_o <= 1'b1;
        resp_addr_o  <= req_addr_i;
        resp_data_o  <= data_q[req_idx];
      end
      if (fill_resp) begin
        resp_valid_o <= 1'b1;
        resp_addr_o  <= mem_req_addr_o;
        resp_data_o  <= mem_resp_data_i;
      end
      if (inval_i) resp_valid_o <= 1'b0;

      if (state_q == S_READY && state_d == S_MISS_REQ) begin
        mem_req_valid_o <= 1'b1;
        mem_req_addr_o  <= req_addr_i;
      end else if (state_q == S_MISS_REQ && state_d != S_MISS_REQ) begin
        mem_req_valid_o <= 1'b0;
      end
    end
  end

  // The array has no reset of its own; every entry to READY goes through the sweep.
  always_ff @(posedge clk_i) begin
    if (state_q == S_CLEAR) valid_q[cnt_q] <= 1'b0;
    else if (fill_we)       valid_q[fill_idx] <= 1'b1;
    if (fill_we) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= mem_resp_data_i;
    end
  end
endmodule

// File: tb/tb_icache_direct.sv
// Directed bench for icache_direct: reset sweep, miss/hit, back-to-back, stall, flush, invalidate.
module tb_icache_direct;
  logic        clk = 1'b0;
  logic        rst_i, flush_i, inval_i;
  logic [29:0] req_addr_i;
  logic        req_valid_i, req_ready_o;
  logic [29:0] resp_addr_o;
  logic [31:0] resp_data_o;
  logic        resp_valid_o, resp_ready_i;
  logic [29:0] mem_req_addr_o;
  logic        mem_req_valid_o, mem_req_ready_i;
  logic [31:0] mem_resp_data_i;
  logic        mem_resp_valid_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mem_lat = 3;
  int mem_cnt = 0;
  int mem_resp_cyc = 0;
  logic [29:0] mem_last_addr = '0;

  logic [29:0] rsp_addr_q[$];
  logic [31:0] rsp_data_q[$];
  int          rsp_cyc_q[$];
  logic [61:0] exp_q[$];

  icache_direct dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .inval_i(inval_i),
    .req_addr_i(req_addr_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .resp_addr_o(resp_addr_o), .resp_data_o(resp_data_o),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_valid_o(mem_req_valid_o),
    .mem_req_ready_i(mem_req_ready_i), .mem_resp_data_i(mem_resp_data_i),
    .mem_resp_valid_i(mem_resp_valid_i)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Backing memory: word at address a holds a + 3; one read at a time, mem_lat cycles.
  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return {2'b00, a} + 32'd3;
  endfunction

  initial begin
    logic [29:0] ma;
    mem_resp_valid_i = 1'b0;
    mem_resp_data_i  = '0;
    forever begin
      @(negedge clk);
      if (mem_req_valid_o && mem_req_ready_i) begin
        ma = mem_req_addr_o;
        mem_cnt++;
        mem_last_addr = ma;
        repeat (mem_lat) @(posedge clk);
        #1 mem_resp_valid_i = 1'b1;
        mem_resp_data_i = mem_word(ma);
        @(posedge clk);
        #1 mem_resp_valid_i = 1'b0;
      end
    end
  end

  // Response monitor
  always @(negedge clk) begin
    if (resp_valid_o && resp_ready_i) begin
      rsp_addr_q.push_back(resp_addr_o);
      rsp_data_q.push_back(resp_data_o);
      rsp_cyc_q.push_back(cyc);
    end
    if (mem_resp_valid_i) mem_resp_cyc = cyc;
  end

  // Driver tasks (all start and end just after a rising edge)
  task automatic send_req(input logic [29:0] a);
    int n;
    n = 0;
    req_addr_i  = a;
    req_valid_i = 1'b1;
    @(negedge clk);
    while (!req_ready_o && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!req_ready_o) begin
      errors++;
      $display("FAIL send_req_timeout addr=%h ready=%b required=1", a, req_ready_o);
    end
    @(posedge clk);
    #1 req_valid_i = 1'b0;
  endtask

  task automatic wait_rsp(input int n, input int bound);
    int k;
    k = 0;
    while (rsp_addr_q.size() < n && k < bound) begin
      @(posedge clk);
      #1;
      k++;
    end
    checks++;
    if (rsp_addr_q.size() < n) begin
      errors++;
      $display("FAIL wait_rsp_timeout got=%0d required=%0d", rsp_addr_q.size(), n);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    rsp_addr_q.delete();
    rsp_data_q.delete();
    rsp_cyc_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    int zc;
    rst_i = 1'b1;
    req_valid_i = 1'b1;
    req_addr_i = 30'h3ff;
    @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    checks += 6;
    if (req_ready_o !== 1'b0)     begin errors++; $display("FAIL rst_req_ready got=%b required=0", req_ready_o); end
    if (resp_valid_o !== 1'b0)    begin errors++; $display("FAIL rst_resp_valid got=%b required=0", resp_valid_o); end
    if (mem_req_valid_o !== 1'b0) begin errors++; $display("FAIL rst_mem_valid got=%b required=0", mem_req_valid_o); end
    if (resp_addr_o !== 30'h0)    begin errors++; $display("FAIL rst_resp_addr got=%h required=0", resp_addr_o); end
    if (resp_data_o !== 32'h0)    begin errors++; $display("FAIL rst_resp_data got=%h required=0", resp_data_o); end
    if (mem_req_addr_o !== 30'h0) begin errors++; $display("FAIL rst_mem_addr got=%h required=0", mem_req_addr_o); end
    zc = 0;
    while (!req_ready_o && zc < 200) begin
      zc++;
      @(negedge clk);
    end
    req_valid_i = 1'b0;
    checks++;
    if (zc != 64) begin errors++; $display("FAIL rst_sweep_cycles got=%0d required=64", zc); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_miss();
    int m0;
    logic [61:0] got;
    clear_obs();
    m0 = mem_cnt;
    send_req(30'h10);
    wait_rsp(1, 30);
    exp_q.push_back({30'h10, 32'h13});
    checks += 3;
    if (mem_cnt - m0 != 1)       begin errors++; $display("FAIL miss_mem_reads got=%0d required=1", mem_cnt - m0); end
    if (mem_last_addr !== 30'h10) begin errors++; $display("FAIL miss_mem_addr got=%h required=10", mem_last_addr); end
    if (rsp_cyc_q.size() == 0 || rsp_cyc_q[0] != mem_resp_cyc + 1) begin
      errors++;
      $display("FAIL miss_latency rsp_cycles=%0d required=1", rsp_cyc_q.size() == 0 ? -1 : rsp_cyc_q[0] - mem_resp_cyc);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < rsp_addr_q.size()) ? {rsp_addr_q[i], rsp_data_q[i]} : '1;
      checks++;
      if (got !== exp_q[i]) begin errors++; $display("FAIL miss_rsp[%0d] got=%h required=%h", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int m0;
    logic [61:0] got;
    clear_obs();
    send_req(30'h11);
    wait_rsp(1, 30);
    clear_obs();
    m0 = mem_cnt;
    send_req(30'h10);
    send_req(30'h11);
    idle(3);
    exp_q.push_back({30'h10, 32'h13});
    exp_q.push_back({30'h11, 32'h14});
    checks += 3;
    if (mem_cnt != m0) begin errors++; $display("FAIL b2b_mem_reads got=%0d required=0", mem_cnt - m0); end
    if (rsp_addr_q.size() != 2) begin errors++; $display("FAIL b2b_count got=%0d required=2", rsp_addr_q.size()); end
    if (rsp_cyc_q.size() < 2 || rsp_cyc_q[1] != rsp_cyc_q[0] + 1) begin
      errors++;
      $display("FAIL b2b_spacing got_responses=%0d required=consecutive", rsp_cyc_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < rsp_addr_q.size()) ? {rsp_addr_q[i], rsp_data_q[i]} : '1;
      checks++;
      if (got !== exp_q[i]) begin errors++; $display("FAIL b2b_rsp[%0d] got=%h required=%h", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_stall();
    logic [61:0] got;
    clear_obs();
    resp_ready_i = 1'b0;
    send_req(30'h10);
    req_addr_i  = 30'h11;
    req_valid_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks += 4;
      if (resp_valid_o !== 1'b1)   begin errors++; $display("FAIL stall_valid[%0d] got=%b required=1", c, resp_valid_o); end
      if (resp_addr_o !== 30'h10)  begin errors++; $display("FAIL stall_addr[%0d] got=%h required=10", c, resp_addr_o); end
      if (resp_data_o !== 32'h13)  begin errors++; $display("FAIL stall_data[%0d] got=%h required=13", c, resp_data_o); end
      if (req_ready_o !== 1'b0)    begin errors++; $display("FAIL stall_req_ready[%0d] got=%b required=0", c, req_ready_o); end
      @(posedge clk);
      #1;
    end
    resp_ready_i = 1'b1;
    send_req(30'h11);
    idle(3);
    exp_q.push_back({30'h10, 32'h13});
    exp_q.push_back({30'h11, 32'h14});
    checks++;
    if (rsp_addr_q.size() != 2) begin errors++; $display("FAIL stall_count got=%0d required=2", rsp_addr_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < rsp_addr_q.size()) ? {rsp_addr_q[i], rsp_data_q[i]} : '1;
      checks++;
      if (got !== exp_q[i]) begin errors++; $display("FAIL stall_rsp[%0d] got=%h required=%h", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_flush();
    int m0;
    logic [61:0] got;
    clear_obs();
    m0 = mem_cnt;
    send_req(30'h20);
    @(posedge clk);
    #1;
    flush_i = 1'b1;
    req_addr_i = 30'h30;
    req_valid_i = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready_o !== 1'b0) begin errors++; $display("FAIL flush_wait_ready got=%b required=0", req_ready_o); end
    @(posedge clk);
    #1 flush_i = 1'b0;
    send_req(30'h30);
    wait_rsp(1, 40);
    idle(2);
    exp_q.push_back({30'h30, 32'h33});
    checks += 2;
    if (rsp_addr_q.size() != 1) begin errors++; $display("FAIL flush_count got=%0d required=1", rsp_addr_q.size()); end
    if (mem_cnt - m0 != 2)      begin errors++; $display("FAIL flush_mem_reads got=%0d required=2", mem_cnt - m0); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < rsp_addr_q.size()) ? {rsp_addr_q[i], rsp_data_q[i]} : '1;
      checks++;
      if (got !== exp_q[i]) begin errors++; $display("FAIL flush_rsp[%0d] got=%h required=%h", i, got, exp_q[i]); end
    end
    clear_obs();
    m0 = mem_cnt;
    send_req(30'h20);
    wait_rsp(1, 10);
    got = (rsp_addr_q.size() > 0) ? {rsp_addr_q[0], rsp_data_q[0]} : '1;
    checks += 2;
    if (mem_cnt != m0) begin errors++; $display("FAIL flush_drained_hit_reads got=%0d required=0", mem_cnt - m0); end
    if (got !== {30'h20, 32'h23}) begin errors++; $display("FAIL flush_drained_hit got=%h required=%h", got, {30'h20, 32'h23}); end
  endtask

  task automatic test_flush_req();
    int m0;
    clear_obs();
    m0 = mem_cnt;
    mem_req_ready_i = 1'b0;
    send_req(30'h21);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks += 2;
      if (mem_req_valid_o !== 1'b1)   begin errors++; $display("FAIL flreq_valid[%0d] got=%b required=1", c, mem_req_valid_o); end
      if (mem_req_addr_o !== 30'h21)  begin errors++; $display("FAIL flreq_addr[%0d] got=%h required=21", c, mem_req_addr_o); end
      @(posedge clk);
      #1;
    end
    flush_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0;
    @(negedge clk);
    checks += 2;
    if (mem_req_valid_o !== 1'b0) begin errors++; $display("FAIL flreq_dropped got=%b required=0", mem_req_valid_o); end
    if (req_ready_o !== 1'b1)     begin errors++; $display("FAIL flreq_ready got=%b required=1", req_ready_o); end
    mem_req_ready_i = 1'b1;
    idle(4);
    checks += 2;
    if (mem_cnt != m0)          begin errors++; $display("FAIL flreq_mem_reads got=%0d required=0", mem_cnt - m0); end
    if (rsp_addr_q.size() != 0) begin errors++; $display("FAIL flreq_count got=%0d required=0", rsp_addr_q.size()); end
  endtask

  task automatic test_conflict_inval();
    int m0, zc;
    logic [61:0] got;
    clear_obs();
    m0 = mem_cnt;
    send_req(30'h05);
    wait_rsp(1, 30);
    send_req(30'h45);
    wait_rsp(2, 30);
    send_req(30'h05);
    wait_rsp(3, 30);
    exp_q.push_back({30'h05, 32'h08});
    exp_q.push_back({30'h45, 32'h48});
    exp_q.push_back({30'h05, 32'h08});
    checks++;
    if (mem_cnt - m0 != 3) begin errors++; $display("FAIL conflict_mem_reads got=%0d required=3", mem_cnt - m0); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < rsp_addr_q.size()) ? {rsp_addr_q[i], rsp_data_q[i]} : '1;
      checks++;
      if (got !== exp_q[i]) begin errors++; $display("FAIL conflict_rsp[%0d] got=%h required=%h", i, got, exp_q[i]); end
    end
    req_addr_i = 30'h45;
    req_valid_i = 1'b1;
    inval_i = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready_o !== 1'b0) begin errors++; $display("FAIL inval_blocks_req got=%b required=0", req_ready_o); end
    @(posedge clk);
    #1 inval_i = 1'b0;
    zc = 0;
    @(negedge clk);
    while (!req_ready_o && zc < 200) begin
      zc++;
      @(negedge clk);
    end
    req_valid_i = 1'b0;
    checks++;
    if (zc != 64) begin errors++; $display("FAIL inval_sweep_cycles got=%0d required=64", zc); end
    @(posedge clk);
    #1;
    clear_obs();
    m0 = mem_cnt;
    send_req(30'h45);
    wait_rsp(1, 30);
    send_req(30'h10);
    wait_rsp(2, 30);
    exp_q.push_back({30'h45, 32'h48});
    exp_q.push_back({30'h10, 32'h13});
    checks++;
    if (mem_cnt - m0 != 2) begin errors++; $display("FAIL inval_mem_reads got=%0d required=2", mem_cnt - m0); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < rsp_addr_q.size()) ? {rsp_addr_q[i], rsp_data_q[i]} : '1;
      checks++;
      if (got !== exp_q[i]) begin errors++; $display("FAIL inval_rsp[%0d] got=%h required=%h", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_inval_pending();
    int m0, zc;
    logic [61:0] got;
    clear_obs();
    m0 = mem_cnt;
    mem_lat = 80;
    send_req(30'h07);
    @(posedge clk);
    #1 inval_i = 1'b1;
    @(posedge clk);
    #1 inval_i = 1'b0;
    mem_lat = 3;
    // Sweep ends 64 cycles after the invalidate; the read returns 15 cycles later.
    zc = 0;
    @(negedge clk);
    while (!req_ready_o && zc < 300) begin
      zc++;
      @(negedge clk);
    end
    checks += 3;
    if (zc != 79)               begin errors++; $display("FAIL pend_busy_cycles got=%0d required=79", zc); end
    if (rsp_addr_q.size() != 0) begin errors++; $display("FAIL pend_no_rsp got=%0d required=0", rsp_addr_q.size()); end
    if (mem_cnt - m0 != 1)      begin errors++; $display("FAIL pend_mem_reads got=%0d required=1", mem_cnt - m0); end
    @(posedge clk);
    #1;
    m0 = mem_cnt;
    send_req(30'h07);
    wait_rsp(1, 30);
    got = (rsp_addr_q.size() > 0) ? {rsp_addr_q[0], rsp_data_q[0]} : '1;
    checks += 2;
    if (mem_cnt - m0 != 1) begin errors++; $display("FAIL pend_refetch got=%0d required=1", mem_cnt - m0); end
    if (got !== {30'h07, 32'h0a}) begin errors++; $display("FAIL pend_rsp got=%h required=%h", got, {30'h07, 32'h0a}); end
  endtask

  initial begin
    rst_i = 1'b1;
    flush_i = 1'b0;
    inval_i = 1'b0;
    req_addr_i = '0;
    req_valid_i = 1'b0;
    resp_ready_i = 1'b1;
    mem_req_ready_i = 1'b1;
    test_reset();
    test_miss();
    test_back_to_back();
    test_stall();
    test_flush();
    test_flush_req();
    test_conflict_inval();
    test_inval_pending();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
